// File: rtl/pattern_scheduler_if.sv
// Control/status bundle between the frame timing logic and the pattern scheduler.
// master drives the requests, slave (the scheduler) drives the pattern selection.
interface pattern_scheduler_if;
  logic       next_frame;
  logic       btn_next;
  logic       btn_speed;
  logic       auto_mode;
  logic [1:0] pattern_sel;
  logic [3:0] pattern_enable;
  logic [2:0] step_size;
  logic       blank;

  modport master (
    output next_frame,
    output btn_next,
    output btn_speed,
    output auto_mode,
    input  pattern_sel,
    input  pattern_enable,
    input  step_size,
    input  blank
  );

  modport slave (
    input  next_frame,
    input  btn_next,
    input  btn_speed,
    input  auto_mode,
    output pattern_sel,
    output pattern_enable,
    output step_size,
    output blank
  );
endinterface

// File: rtl/pattern_scheduler.sv
// Test-pattern scheduler: SHOW/BLANK sequencing, dwell timing and speed control.
// Optional SPEED_RAMP_EN: step_size ramps from 1 up to the speed setting on pattern entry.
module pattern_scheduler #(
  parameter int unsigned DWELL_FRAMES = 240,
  parameter int unsigned BLANK_FRAMES = 4
) (
  input  logic               clk,
  input  logic               rst,
  pattern_scheduler_if.slave bus
);

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } state_e;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL_FRAMES);
  localparam logic [3:0] BLANK_LAST = 4'(BLANK_FRAMES);

  state_e     state_q, state_d;
  logic [7:0] dwell_q, dwell_d;
  logic [3:0] blank_q, blank_d;
  logic [1:0] sel_q, sel_d;
  logic [2:0] speed_q, speed_d;
  logic       to_show;

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    blank_d = blank_q;
    sel_d   = sel_q;
    to_show = 1'b0;
    unique case (state_q)
      SHOW: begin
        blank_d = '0;
        // a manual request beats a coincident frame tick
        if (bus.btn_next) begin
          state_d = BLANK;
          dwell_d = '0;
        end else if (bus.auto_mode && bus.next_frame) begin
          if (dwell_q + 8'd1 == DWELL_LAST) begin
            state_d = BLANK;
            dwell_d = '0;
          end else begin
            dwell_d = dwell_q + 8'd1;
          end
        end
      end
      BLANK: begin
        if (bus.next_frame) begin
          if (blank_q + 4'd1 == BLANK_LAST) begin
            state_d = SHOW;
            sel_d   = sel_q + 2'd1;
            blank_d = '0;
            dwell_d = '0;
            to_show = 1'b1;
          end else begin
            blank_d = blank_q + 4'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    speed_d = speed_q;
    if (bus.btn_speed) begin
      speed_d = (speed_q == 3'd7) ? 3'd1 : speed_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SHOW;
      dwell_q <= '0;
      blank_q <= '0;
      sel_q   <= '0;
      speed_q <= 3'd2;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      blank_q <= blank_d;
      sel_q   <= sel_d;
      speed_q <= speed_d;
    end
  end

`ifdef SPEED_RAMP_EN
  logic [2:0] step_q, step_d;

  always_comb begin
    step_d = step_q;
    if (to_show) begin
      step_d = 3'd1;
    end else if (speed_d < step_q) begin
      step_d = speed_d;
    end else if (state_q == SHOW && bus.next_frame && step_q < speed_d) begin
      step_d = step_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= 3'd2;
    end else begin
      step_q <= step_d;
    end
  end

  assign bus.step_size = step_q;
`else
  assign bus.step_size = speed_q;
`endif

  assign bus.pattern_sel    = sel_q;
  assign bus.blank          = (state_q == BLANK);
  assign bus.pattern_enable = (state_q == SHOW) ? (4'b0001 << sel_q) : 4'b0000;

endmodule

// File: tb/tb_pattern_scheduler.sv
// Self-checking bench for pattern_scheduler: directed table, corner sequences,
// and randomized traffic against a frame-level reference model.
module tb_pattern_scheduler;

  localparam int DW = 240;
  localparam int BF = 4;

  logic clk = 1'b0;
  logic rst;

  pattern_scheduler_if bus ();

  pattern_scheduler #(
    .DWELL_FRAMES(DW),
    .BLANK_FRAMES(BF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  bit m_blank;
  int m_dw, m_bc, m_pat, m_speed, m_step;

  typedef struct {
    bit         bn, nf, bs;
    logic [1:0] sel;
    logic [3:0] en;
    logic [2:0] step;
    bit         blk;
  } vec_t;

  vec_t tbl [12];

  function automatic void m_reset();
    m_blank = 0;
    m_dw    = 0;
    m_bc    = 0;
    m_pat   = 0;
    m_speed = 2;
    m_step  = 2;
  endfunction

  function automatic void m_edge(bit bn, bit nf, bit bs, bit au);
    bit was_show = !m_blank;
    bit entered  = 0;
    if (m_blank) begin
      if (nf) begin
        m_bc++;
        if (m_bc == BF) begin
          m_blank = 0;
          m_pat   = (m_pat + 1) % 4;
          m_bc    = 0;
          m_dw    = 0;
          entered = 1;
        end
      end
    end else if (bn) begin
      m_blank = 1;
      m_dw    = 0;
    end else if (au && nf) begin
      m_dw++;
      if (m_dw == DW) begin
        m_blank = 1;
        m_dw    = 0;
      end
    end
    if (bs) m_speed = m_speed % 7 + 1;
    if (entered) m_step = 1;
    else if (m_speed < m_step) m_step = m_speed;
    else if (was_show && nf && m_step < m_speed) m_step++;
  endfunction

  function automatic logic [15:0] m_out();
    logic [3:0] en;
    logic [2:0] st;
    en = m_blank ? 4'b0000 : (4'b0001 << m_pat);
`ifdef SPEED_RAMP_EN
    st = 3'(m_step);
`else
    st = 3'(m_speed);
`endif
    return {6'd0, 2'(m_pat), en, st, m_blank};
  endfunction

  function automatic logic [15:0] dut_o();
    return {6'd0, bus.pattern_sel, bus.pattern_enable, bus.step_size, bus.blank};
  endfunction

  function automatic logic [15:0] vis();
    return {9'd0, bus.pattern_sel, bus.pattern_enable, bus.blank};
  endfunction

  task automatic check(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(bit bn, bit nf, bit bs, bit au);
    @(negedge clk);
    bus.btn_next   = bn;
    bus.next_frame = nf;
    bus.btn_speed  = bs;
    bus.auto_mode  = au;
    @(posedge clk);
    m_edge(bn, nf, bs, au);
    #1;
    check("model", dut_o(), m_out());
    bus.btn_next   = 1'b0;
    bus.next_frame = 1'b0;
    bus.btn_speed  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    bus.btn_next   = 1'b0;
    bus.next_frame = 1'b0;
    bus.btn_speed  = 1'b0;
    m_reset();
    #1;
    check("reset", dut_o(), 16'b00_0001_010_0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic manual();
    cyc(1, 0, 0, 0);
    repeat (BF) cyc(0, 1, 0, 0);
  endtask

  initial begin
    int exp_s [6];
    bit au;
    exp_s = '{3, 4, 5, 6, 7, 1};

    rst            = 1'b1;
    bus.btn_next   = 1'b0;
    bus.next_frame = 1'b0;
    bus.btn_speed  = 1'b0;
    bus.auto_mode  = 1'b0;
    m_reset();
    #3;
    check("reset_state", dut_o(), 16'b00_0001_010_0);
    @(negedge clk);
    rst = 1'b0;

`ifndef SPEED_RAMP_EN
    tbl[0]  = '{0, 0, 0, 2'd0, 4'b0001, 3'd2, 0};
    tbl[1]  = '{0, 0, 1, 2'd0, 4'b0001, 3'd3, 0};
    tbl[2]  = '{1, 0, 0, 2'd0, 4'b0000, 3'd3, 1};
    tbl[3]  = '{1, 1, 0, 2'd0, 4'b0000, 3'd3, 1};
    tbl[4]  = '{0, 1, 0, 2'd0, 4'b0000, 3'd3, 1};
    tbl[5]  = '{0, 1, 1, 2'd0, 4'b0000, 3'd4, 1};
    tbl[6]  = '{0, 1, 0, 2'd1, 4'b0010, 3'd4, 0};
    tbl[7]  = '{1, 1, 0, 2'd1, 4'b0000, 3'd4, 1};
    tbl[8]  = '{0, 1, 0, 2'd1, 4'b0000, 3'd4, 1};
    tbl[9]  = '{0, 1, 0, 2'd1, 4'b0000, 3'd4, 1};
    tbl[10] = '{0, 1, 0, 2'd1, 4'b0000, 3'd4, 1};
    tbl[11] = '{0, 1, 0, 2'd2, 4'b0100, 3'd4, 0};
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].bn, tbl[i].nf, tbl[i].bs, 0);
      check($sformatf("table%0d", i), dut_o(),
            {6'd0, tbl[i].sel, tbl[i].en, tbl[i].step, tbl[i].blk});
    end
`endif

    // auto dwell then blanking
    do_reset();
    repeat (DW - 1) cyc(0, 1, 0, 1);
    check("dwell_239", vis(), 16'b00_0001_0);
    cyc(0, 1, 0, 1);
    check("dwell_240", vis(), 16'b00_0000_1);
    repeat (BF - 1) cyc(0, 1, 0, 1);
    check("blank_3", vis(), 16'b00_0000_1);
    cyc(0, 1, 0, 1);
    check("auto_adv", vis(), 16'b01_0010_0);

    // manual mode holds, blank ignores btn_next
    do_reset();
    repeat (1000) cyc(0, 1, 0, 0);
    check("hold_1000", vis(), 16'b00_0001_0);
    cyc(1, 0, 0, 0);
    check("btn_blank", vis(), 16'b00_0000_1);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    repeat (BF - 1) cyc(0, 1, 0, 0);
    check("btn_ignored", vis(), 16'b01_0010_0);

    manual();
    manual();
    check("sel3", vis(), 16'b11_1000_0);
    manual();
    check("wrap", vis(), 16'b00_0001_0);

    // coincident btn_next and final dwell frame
    do_reset();
    repeat (DW - 1) cyc(0, 1, 0, 1);
    cyc(1, 1, 0, 1);
    check("coinc_blank", vis(), 16'b00_0000_1);
    repeat (BF) cyc(0, 1, 0, 1);
    check("coinc_once", vis(), 16'b01_0010_0);
    repeat (DW - 1) cyc(0, 1, 0, 1);
    check("dwell_clr", vis(), 16'b01_0010_0);
    cyc(0, 1, 0, 1);
    check("dwell_clr2", vis(), 16'b01_0000_1);

    do_reset();
`ifndef SPEED_RAMP_EN
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 1, 0);
      check($sformatf("speed%0d", i), 16'(bus.step_size), 16'(exp_s[i]));
    end
`else
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    repeat (BF) cyc(0, 1, 0, 0);
    check("ramp0", 16'(bus.step_size), 16'd1);
    for (int i = 2; i <= 5; i++) begin
      cyc(0, 1, 0, 0);
      check($sformatf("ramp%0d", i), 16'(bus.step_size), 16'(i > 4 ? 4 : i));
    end
`endif

    // reset in the middle of blanking, no clock edge
    do_reset();
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    #2;
    rst = 1'b1;
    m_reset();
    #1;
    check("async_rst", vis(), 16'b00_0001_0);
    @(negedge clk);
    rst = 1'b0;

    do_reset();
    au = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(199) == 0) au = !au;
      cyc($urandom_range(23) == 0, $urandom_range(2) == 0,
          $urandom_range(19) == 0, au);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
